// File: rtl/pipe_ctrl_hazard.sv
// Pipelined control unit for the 5-stage MIPS core: ID decode, ID/EX, EX/MEM, MEM/WB
// control registers, load-use stall, branch/jump flush and forwarding selects.
module pipe_ctrl_hazard #(
  parameter int unsigned AW        = 5,
  parameter int unsigned ALUCTRL_W = 5,
  parameter int unsigned EXT_W     = 2,
  parameter int unsigned HAZARD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          id_instr_i,
  input  logic                 id_valid_i,
  input  logic                 ex_zero_i,
  input  logic                 stall_ext_i,
  output logic                 pc_stall_o,
  output logic                 ifid_stall_o,
  output logic                 ifid_flush_o,
  output logic                 branch_taken_o,
  output logic                 jump_taken_o,
  output logic                 jr_sel_o,
  output logic                 illegal_op_o,
  output logic                 ex_alusrc_o,
  output logic [ALUCTRL_W-1:0] ex_aluctrl_o,
  output logic [EXT_W-1:0]     ex_extop_o,
  output logic [AW-1:0]        ex_rs_o,
  output logic [AW-1:0]        ex_rt_o,
  output logic [AW-1:0]        ex_waddr_o,
  output logic                 mem_memr_o,
  output logic                 mem_memw_o,
  output logic                 wb_regw_o,
  output logic                 wb_mem2r_o,
  output logic [AW-1:0]        wb_waddr_o,
  output logic [1:0]           fwd_a_o,
  output logic [1:0]           fwd_b_o
);

  localparam logic [ALUCTRL_W-1:0] ALU_NOP  = ALUCTRL_W'(0);
  localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(1);
  localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(2);
  localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(3);
  localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(4);
  localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(5);
  localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(6);
  localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(7);
  localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(8);
  localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(9);
  localparam logic [ALUCTRL_W-1:0] ALU_LUI  = ALUCTRL_W'(10);
  localparam logic [ALUCTRL_W-1:0] ALU_ADDU = ALUCTRL_W'(11);
  localparam logic [ALUCTRL_W-1:0] ALU_SUBU = ALUCTRL_W'(12);

  localparam logic [EXT_W-1:0] EXT_ZERO = EXT_W'(0);
  localparam logic [EXT_W-1:0] EXT_SIGN = EXT_W'(1);
  localparam logic [EXT_W-1:0] EXT_HIGH = EXT_W'(2);

  typedef struct packed {
    logic                 regw;
    logic                 memr;
    logic                 memw;
    logic                 mem2r;
    logic                 branch;
    logic                 bne;
    logic                 alusrc;
    logic [ALUCTRL_W-1:0] aluctrl;
    logic [EXT_W-1:0]     extop;
    logic [AW-1:0]        rs;
    logic [AW-1:0]        rt;
    logic [AW-1:0]        waddr;
  } ctrl_t;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       unused_shamt;

  assign opcode       = id_instr_i[31:26];
  assign funct        = id_instr_i[5:0];
  assign unused_shamt = ^id_instr_i[10:6];

  ctrl_t id_ctrl;
  logic  id_jump;
  logic  id_jr;
  logic  id_uses_rt;
  logic  id_known;
  logic  id_regdst;

  // ID decode; anything not decodable or not valid collapses to a bubble
  always_comb begin
    id_ctrl    = '0;
    id_jump    = 1'b0;
    id_jr      = 1'b0;
    id_uses_rt = 1'b0;
    id_known   = 1'b1;
    id_regdst  = 1'b0;
    case (opcode)
      6'b000000: begin
        id_regdst    = 1'b1;
        id_uses_rt   = 1'b1;
        id_ctrl.regw = 1'b1;
        case (funct)
          6'b100001: id_ctrl.aluctrl = ALU_ADDU;
          6'b100011: id_ctrl.aluctrl = ALU_SUBU;
          6'b100000: id_ctrl.aluctrl = ALU_ADD;
          6'b100010: id_ctrl.aluctrl = ALU_SUB;
          6'b100100: id_ctrl.aluctrl = ALU_AND;
          6'b100101: id_ctrl.aluctrl = ALU_OR;
          6'b100110: id_ctrl.aluctrl = ALU_XOR;
          6'b000000: id_ctrl.aluctrl = ALU_SLL;
          6'b000010: id_ctrl.aluctrl = ALU_SRL;
          6'b000011: id_ctrl.aluctrl = ALU_SRA;
          6'b101010: id_ctrl.aluctrl = ALU_SLT;
          6'b001000: begin
            id_ctrl.regw = 1'b0;
            id_jump      = 1'b1;
            id_jr        = 1'b1;
          end
          default:   id_known = 1'b0;
        endcase
      end
      6'b001101: begin
        id_ctrl.regw    = 1'b1;
        id_ctrl.alusrc  = 1'b1;
        id_ctrl.aluctrl = ALU_OR;
        id_ctrl.extop   = EXT_ZERO;
      end
      6'b001111: begin
        id_ctrl.regw    = 1'b1;
        id_ctrl.alusrc  = 1'b1;
        id_ctrl.aluctrl = ALU_LUI;
        id_ctrl.extop   = EXT_HIGH;
      end
      6'b101011: begin
        id_uses_rt      = 1'b1;
        id_ctrl.memw    = 1'b1;
        id_ctrl.alusrc  = 1'b1;
        id_ctrl.aluctrl = ALU_ADD;
        id_ctrl.extop   = EXT_SIGN;
      end
      6'b100011: begin
        id_ctrl.regw    = 1'b1;
        id_ctrl.memr    = 1'b1;
        id_ctrl.mem2r   = 1'b1;
        id_ctrl.alusrc  = 1'b1;
        id_ctrl.aluctrl = ALU_ADD;
        id_ctrl.extop   = EXT_SIGN;
      end
      6'b000100, 6'b000101: begin
        id_uses_rt      = 1'b1;
        id_ctrl.branch  = 1'b1;
        id_ctrl.bne     = opcode[0];
        id_ctrl.aluctrl = ALU_SUB;
        id_ctrl.extop   = EXT_SIGN;
      end
      6'b001000: begin
        id_ctrl.regw    = 1'b1;
        id_ctrl.alusrc  = 1'b1;
        id_ctrl.aluctrl = ALU_ADD;
        id_ctrl.extop   = EXT_SIGN;
      end
      6'b000010: id_jump = 1'b1;
      default:   id_known = 1'b0;
    endcase

    id_ctrl.rs    = AW'(id_instr_i[25:21]);
    id_ctrl.rt    = AW'(id_instr_i[20:16]);
    id_ctrl.waddr = id_regdst ? AW'(id_instr_i[15:11]) : AW'(id_instr_i[20:16]);
    // j carries instr_index where rs/rt would be; jumps never write a register
    if (id_jump) begin
      id_ctrl.rt    = '0;
      id_ctrl.waddr = '0;
      if (!id_jr) id_ctrl.rs = '0;
    end
    if (id_ctrl.waddr == '0) id_ctrl.regw = 1'b0;
    if (!id_known || !id_valid_i) begin
      id_ctrl    = '0;
      id_jump    = 1'b0;
      id_jr      = 1'b0;
      id_uses_rt = 1'b0;
    end
    if (id_ctrl.waddr == '0) id_ctrl.regw = 1'b0;
  end

  ctrl_t         ex_q, ex_d;
  logic          mem_regw_q, mem_memr_q, mem_memw_q, mem_mem2r_q;
  logic [AW-1:0] mem_waddr_q;
  logic          wb_regw_q, wb_mem2r_q;
  logic [AW-1:0] wb_waddr_q;

  logic lu_hit;
  logic load_use;
  logic branch_taken;

  assign branch_taken = ex_q.branch & (ex_zero_i ^ ex_q.bne) & ~stall_ext_i;
  assign lu_hit = (HAZARD_EN != 0) && ex_q.memr && (ex_q.waddr != '0) &&
                  ((ex_q.waddr == id_ctrl.rs) || (id_uses_rt && (ex_q.waddr == id_ctrl.rt)));
  assign load_use = lu_hit & ~branch_taken & ~stall_ext_i;

  // Squash the ID instruction on a taken branch or a load-use stall
  always_comb begin
    ex_d = id_ctrl;
    if (branch_taken || load_use) ex_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q        <= '0;
      mem_regw_q  <= 1'b0;
      mem_memr_q  <= 1'b0;
      mem_memw_q  <= 1'b0;
      mem_mem2r_q <= 1'b0;
      mem_waddr_q <= '0;
      wb_regw_q   <= 1'b0;
      wb_mem2r_q  <= 1'b0;
      wb_waddr_q  <= '0;
    end else if (!stall_ext_i) begin
      ex_q        <= ex_d;
      mem_regw_q  <= ex_q.regw;
      mem_memr_q  <= ex_q.memr;
      mem_memw_q  <= ex_q.memw;
      mem_mem2r_q <= ex_q.mem2r;
      mem_waddr_q <= ex_q.waddr;
      wb_regw_q   <= mem_regw_q;
      wb_mem2r_q  <= mem_mem2r_q;
      wb_waddr_q  <= mem_waddr_q;
    end
  end

  // Forwarding selects; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a_o = 2'b00;
    fwd_b_o = 2'b00;
    if (HAZARD_EN != 0) begin
      if (mem_regw_q && (mem_waddr_q != '0) && (mem_waddr_q == ex_q.rs)) fwd_a_o = 2'b10;
      else if (wb_regw_q && (wb_waddr_q != '0) && (wb_waddr_q == ex_q.rs)) fwd_a_o = 2'b01;
      if (mem_regw_q && (mem_waddr_q != '0) && (mem_waddr_q == ex_q.rt)) fwd_b_o = 2'b10;
      else if (wb_regw_q && (wb_waddr_q != '0) && (wb_waddr_q == ex_q.rt)) fwd_b_o = 2'b01;
    end
  end

  assign pc_stall_o     = load_use | stall_ext_i;
  assign ifid_stall_o   = load_use | stall_ext_i;
  assign branch_taken_o = branch_taken;
  assign jump_taken_o   = id_jump & id_valid_i & ~lu_hit & ~branch_taken & ~stall_ext_i;
  assign ifid_flush_o   = branch_taken | jump_taken_o;
  assign jr_sel_o       = id_jr;
  assign illegal_op_o   = id_valid_i & ~id_known;

  assign ex_alusrc_o  = ex_q.alusrc;
  assign ex_aluctrl_o = ex_q.aluctrl;
  assign ex_extop_o   = ex_q.extop;
  assign ex_rs_o      = ex_q.rs;
  assign ex_rt_o      = ex_q.rt;
  assign ex_waddr_o   = ex_q.waddr;
  assign mem_memr_o   = mem_memr_q;
  assign mem_memw_o   = mem_memw_q;
  assign wb_regw_o    = wb_regw_q;
  assign wb_mem2r_o   = wb_mem2r_q;
  assign wb_waddr_o   = wb_waddr_q;

endmodule

// File: tb/tb_pipe_ctrl_hazard.sv
// Directed bench for pipe_ctrl_hazard: hazards, forwarding, flushes, illegal ops,
// external stall and reset, with hand-computed expectations.
module tb_pipe_ctrl_hazard;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        id_valid, ex_zero, stall_ext;
  logic        pc_stall, ifid_stall, ifid_flush, branch_taken, jump_taken, jr_sel, illegal_op;
  logic        ex_alusrc;
  logic [4:0]  ex_aluctrl;
  logic [1:0]  ex_extop;
  logic [4:0]  ex_rs, ex_rt, ex_waddr;
  logic        mem_memr, mem_memw, wb_regw, wb_mem2r;
  logic [4:0]  wb_waddr;
  logic [1:0]  fwd_a, fwd_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl_hazard dut (
    .clk(clk), .rst(rst), .id_instr_i(id_instr), .id_valid_i(id_valid),
    .ex_zero_i(ex_zero), .stall_ext_i(stall_ext),
    .pc_stall_o(pc_stall), .ifid_stall_o(ifid_stall), .ifid_flush_o(ifid_flush),
    .branch_taken_o(branch_taken), .jump_taken_o(jump_taken), .jr_sel_o(jr_sel),
    .illegal_op_o(illegal_op), .ex_alusrc_o(ex_alusrc), .ex_aluctrl_o(ex_aluctrl),
    .ex_extop_o(ex_extop), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt), .ex_waddr_o(ex_waddr),
    .mem_memr_o(mem_memr), .mem_memw_o(mem_memw), .wb_regw_o(wb_regw),
    .wb_mem2r_o(wb_mem2r), .wb_waddr_o(wb_waddr), .fwd_a_o(fwd_a), .fwd_b_o(fwd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic valid);
    id_instr = instr;
    id_valid = valid;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      drive(32'h0, 1'b0);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000000, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_JR  = 6'b001000;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] lw1, add213, add123, sub411, add023, sub400, beq11, bne11, add567;
    logic [31:0] jr1, j40, ori501, lui7, sw9;
    lw1    = itype(6'b100011, 5'd0, 5'd1, 16'h0000);
    add213 = rtype(5'd1, 5'd3, 5'd2, F_ADD);
    add123 = rtype(5'd2, 5'd3, 5'd1, F_ADD);
    sub411 = rtype(5'd1, 5'd1, 5'd4, F_SUB);
    add023 = rtype(5'd2, 5'd3, 5'd0, F_ADD);
    sub400 = rtype(5'd0, 5'd0, 5'd4, F_SUB);
    beq11  = itype(6'b000100, 5'd1, 5'd1, 16'h0004);
    bne11  = itype(6'b000101, 5'd1, 5'd1, 16'h0004);
    add567 = rtype(5'd6, 5'd7, 5'd5, F_ADD);
    jr1    = rtype(5'd1, 5'd0, 5'd0, F_JR);
    j40    = {6'b000010, 26'h0000040};
    ori501 = itype(6'b001101, 5'd0, 5'd5, 16'h0001);
    lui7   = itype(6'b001111, 5'd0, 5'd7, 16'h1234);
    sw9    = itype(6'b101011, 5'd1, 5'd9, 16'h0004);

    rst = 1'b1; id_instr = '0; id_valid = 1'b0; ex_zero = 1'b0; stall_ext = 1'b0;
    tick(); tick();
    rst = 1'b0;
    drive(32'h0, 1'b0);
    chk("rst_ex_waddr", ex_waddr, 0);
    chk("rst_mem_memr", mem_memr, 0);
    chk("rst_wb_regw", wb_regw, 0);
    chk("rst_pc_stall", pc_stall, 0);
    chk("rst_fwd_a", fwd_a, 0);

    // lw $1 ; add $2,$1,$3 back-to-back
    tick(); drive(lw1, 1'b1);
    chk("lu_pre_stall", pc_stall, 0);
    tick(); drive(add213, 1'b1);
    chk("lu_ex_waddr", ex_waddr, 1);
    chk("lu_pc_stall", pc_stall, 1);
    chk("lu_ifid_stall", ifid_stall, 1);
    chk("lu_ifid_flush", ifid_flush, 0);
    tick(); drive(add213, 1'b1);
    chk("lu_stall_1cyc", pc_stall, 0);
    chk("lu_ex_bubble_waddr", ex_waddr, 0);
    chk("lu_ex_bubble_rs", ex_rs, 0);
    chk("lu_mem_memr", mem_memr, 1);
    tick(); drive(32'h0, 1'b0);
    chk("lu_add_rs", ex_rs, 1);
    chk("lu_add_waddr", ex_waddr, 2);
    chk("lu_fwd_a", fwd_a, 2'b01);
    chk("lu_fwd_b", fwd_b, 2'b00);
    chk("lu_wb_mem2r", wb_mem2r, 1);
    chk("lu_wb_waddr", wb_waddr, 1);
    idle(3);

    // add $1 ; sub $4,$1,$1 -> EX/MEM forwarding
    tick(); drive(add123, 1'b1);
    tick(); drive(sub411, 1'b1);
    chk("fw_no_stall", pc_stall, 0);
    tick(); drive(32'h0, 1'b0);
    chk("fw10_a", fwd_a, 2'b10);
    chk("fw10_b", fwd_b, 2'b10);
    chk("fw_sub_aluctrl", ex_aluctrl, 5'd2);
    idle(3);

    // one nop between -> MEM/WB forwarding
    tick(); drive(add123, 1'b1);
    tick(); drive(32'h0, 1'b1);
    tick(); drive(sub411, 1'b1);
    tick(); drive(32'h0, 1'b0);
    chk("fw01_a", fwd_a, 2'b01);
    chk("fw01_b", fwd_b, 2'b01);
    idle(3);

    // destination $0 never forwards nor writes
    tick(); drive(add023, 1'b1);
    tick(); drive(sub400, 1'b1);
    tick(); drive(32'h0, 1'b0);
    chk("fw0_a", fwd_a, 2'b00);
    chk("fw0_b", fwd_b, 2'b00);
    tick(); drive(32'h0, 1'b0);
    chk("dst0_wb_regw", wb_regw, 0);
    idle(3);

    // beq taken, younger instruction squashed
    tick(); drive(beq11, 1'b1);
    tick(); ex_zero = 1'b1; drive(add567, 1'b1);
    chk("beq_taken", branch_taken, 1);
    chk("beq_flush", ifid_flush, 1);
    chk("beq_pc_stall", pc_stall, 0);
    tick(); drive(32'h0, 1'b0);
    chk("beq_ex_bubble", ex_waddr, 0);
    chk("beq_bubble_no_branch", branch_taken, 0);
    ex_zero = 1'b0;

    // bne with zero set is not taken
    tick(); drive(bne11, 1'b1);
    tick(); ex_zero = 1'b1; drive(add567, 1'b1);
    chk("bne_not_taken", branch_taken, 0);
    chk("bne_no_flush", ifid_flush, 0);
    tick(); ex_zero = 1'b0; drive(32'h0, 1'b0);
    chk("bne_next_ex", ex_waddr, 5);
    idle(2);

    // jr $1 behind lw $1: held until the stall clears
    tick(); drive(lw1, 1'b1);
    tick(); drive(jr1, 1'b1);
    chk("jr_blocked", jump_taken, 0);
    chk("jr_stall", pc_stall, 1);
    chk("jr_sel", jr_sel, 1);
    tick(); drive(jr1, 1'b1);
    chk("jr_taken", jump_taken, 1);
    chk("jr_flush", ifid_flush, 1);
    chk("jr_no_stall", pc_stall, 0);
    tick(); drive(32'h0, 1'b0);
    chk("jr_ex_nowrite", ex_waddr, 0);
    tick(); drive(j40, 1'b1);
    chk("j_taken", jump_taken, 1);
    chk("j_sel", jr_sel, 0);
    chk("j_flush", ifid_flush, 1);
    idle(2);

    // illegal opcode 111111
    tick(); drive(32'hFC22_0000, 1'b1);
    chk("ill_pulse", illegal_op, 1);
    chk("ill_no_stall", pc_stall, 0);
    tick(); drive(32'h0, 1'b0);
    chk("ill_pulse_end", illegal_op, 0);
    chk("ill_ex_rt", ex_rt, 0);
    tick(); drive(32'h0, 1'b0);
    chk("ill_mem_memw", mem_memw, 0);
    tick(); drive(32'h0, 1'b0);
    chk("ill_wb_regw", wb_regw, 0);

    // decode spot checks
    tick(); drive(lui7, 1'b1);
    tick(); drive(ori501, 1'b1);
    chk("lui_aluctrl", ex_aluctrl, 5'd10);
    chk("lui_extop", ex_extop, 2'd2);
    chk("lui_alusrc", ex_alusrc, 1);
    chk("lui_waddr", ex_waddr, 7);
    tick(); drive(sw9, 1'b1);
    chk("ori_aluctrl", ex_aluctrl, 5'd4);
    chk("ori_extop", ex_extop, 2'd0);
    tick(); drive(32'h0, 1'b0);
    chk("sw_extop", ex_extop, 2'd1);
    chk("sw_rt", ex_rt, 9);
    tick(); drive(32'h0, 1'b0);
    chk("sw_mem_memw", mem_memw, 1);
    idle(3);

    // external stall for 3 cycles freezes everything
    tick(); drive(add123, 1'b1);
    tick(); stall_ext = 1'b1; drive(sub411, 1'b1);
    chk("sx_pc_stall", pc_stall, 1);
    chk("sx_ifid_stall", ifid_stall, 1);
    repeat (3) begin
      tick();
      chk("sx_hold_waddr", ex_waddr, 1);
      chk("sx_hold_rs", ex_rs, 2);
    end
    stall_ext = 1'b0;
    tick(); drive(32'h0, 1'b0);
    chk("sx_resume_waddr", ex_waddr, 4);
    chk("sx_resume_fwd_a", fwd_a, 2'b10);
    idle(3);

    // reset while stalled externally
    tick(); drive(lw1, 1'b1);
    tick(); drive(ori501, 1'b1);
    tick(); drive(32'h0, 1'b0);
    chk("rsx_pre_memr", mem_memr, 1);
    chk("rsx_pre_alusrc", ex_alusrc, 1);
    stall_ext = 1'b1; rst = 1'b1;
    tick();
    chk("rsx_alusrc", ex_alusrc, 0);
    chk("rsx_waddr", ex_waddr, 0);
    chk("rsx_aluctrl", ex_aluctrl, 0);
    chk("rsx_memr", mem_memr, 0);
    chk("rsx_wb_regw", wb_regw, 0);
    rst = 1'b0; stall_ext = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
